// File: rtl/alu_issue.sv
// alu_issue: sequencing front-end for a 4-bit combinational ALU.
// It holds a small register file and takes register-addressed instructions over
// a valid/ready handshake. Each instruction runs through IDLE -> EXEC -> WB:
// operands are latched at accept, the ALU result is captured at the end of EXEC,
// and the result is written back and reported in WB.
module alu_issue #(
    parameter int W    = 4,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_oc,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic [2:0]    alu_oc,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_f,
    output logic          out_valid,
    output logic [AW-1:0] out_rd,
    output logic [W-1:0]  out_data,
    output logic          div0,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam logic [2:0] OC_DIV = 3'd3;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t        state, state_n;
    logic          accept;
    logic [W-1:0]  regs [NREG];
    logic [AW-1:0] rd_q;
    logic          div0_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and handshake; a load in IDLE blocks acceptance for that cycle.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~ld_en;
                accept   = in_valid & ~ld_en;
                if (accept) state_n = EXEC;
            end
            EXEC:    state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Register file: direct loads only in IDLE, writeback in WB; loads elsewhere are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == IDLE && ld_en) begin
            regs[ld_addr] <= ld_data;
        end else if (state == WB) begin
            regs[rd_q] <= out_data;
        end
    end

    // Datapath: operands latched at accept drive the ALU through EXEC; result and
    // destination are captured at the end of EXEC and then held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_oc   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rd_q     <= '0;
            out_rd   <= '0;
            out_data <= '0;
            div0_q   <= 1'b0;
        end else begin
            if (accept) begin
                alu_oc <= in_oc;
                alu_a  <= regs[in_rs1];
                alu_b  <= regs[in_rs2];
                rd_q   <= in_rd;
            end
            if (state == EXEC) begin
                out_data <= alu_f;
                out_rd   <= rd_q;
                div0_q   <= (alu_oc == OC_DIV) && (alu_b == '0);
            end
        end
    end

    assign out_valid = (state == WB);
    assign div0      = out_valid & div0_q;
    assign rd_data   = regs[rd_addr];

endmodule
